// File: rtl/ram_bubble_sorter.sv
// In-place unsigned bubble sort controller for a single-port RAM with
// synchronous write and registered-address read; owns the RAM port while BUSY.
module ram_bubble_sorter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DESCEND    = 0
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [2*ADDR_WIDTH-1:0] SWAP_COUNT,
    output logic [ADDR_WIDTH-1:0]   RAM_ADDR,
    output logic [DATA_WIDTH-1:0]   RAM_DIN,
    output logic                    RAM_WE,
    input  logic [DATA_WIDTH-1:0]   RAM_DOUT
);

    localparam int CW = 2 * ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LIM_INIT = ADDR_WIDTH'((1 << ADDR_WIDTH) - 2);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, FIN
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   j, lim, j_inc;
    logic                    sw;
    logic [DATA_WIDTH-1:0]   a, b;
    logic [CW-1:0]           swap_count;
    logic                    swap_needed;
    logic                    pass_end;
    logic                    finish;

    assign j_inc       = j + ADDR_WIDTH'(1);
    assign swap_needed = (DESCEND != 0) ? (a < RAM_DOUT) : (a > RAM_DOUT);
    assign pass_end    = (j >= lim);
    assign finish      = pass_end && (!sw || (lim == '0));
    assign SWAP_COUNT  = swap_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = CMP;
            CMP:     state_nxt = swap_needed ? WR_A : NEXT;
            WR_A:    state_nxt = WR_B;
            WR_B:    state_nxt = NEXT;
            NEXT:    state_nxt = finish ? FIN : RD_A;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port is a pure decode of the state and index registers
    always_comb begin
        RAM_ADDR = '0;
        RAM_DIN  = '0;
        RAM_WE   = 1'b0;
        case (state)
            RD_A:      RAM_ADDR = j;
            RD_B, CMP: RAM_ADDR = j_inc;
            WR_A: begin
                RAM_ADDR = j;
                RAM_DIN  = b;
                RAM_WE   = 1'b1;
            end
            WR_B: begin
                RAM_ADDR = j_inc;
                RAM_DIN  = a;
                RAM_WE   = 1'b1;
            end
            default: ;
        endcase
        BUSY = (state != IDLE) && (state != FIN);
        DONE = (state == FIN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            j          <= '0;
            lim        <= '0;
            sw         <= 1'b0;
            a          <= '0;
            b          <= '0;
            swap_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        j          <= '0;
                        lim        <= LIM_INIT;
                        sw         <= 1'b0;
                        swap_count <= '0;
                    end
                end
                RD_B: a <= RAM_DOUT;
                CMP:  b <= RAM_DOUT;
                WR_B: begin
                    sw         <= 1'b1;
                    swap_count <= swap_count + CW'(1);
                end
                NEXT: begin
                    if (!pass_end) begin
                        j <= j_inc;
                    end else if (!finish) begin
                        lim <= lim - ADDR_WIDTH'(1);
                        j   <= '0;
                        sw  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
